// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants, types and helpers for the UART frame checking path.
//   PARITY_*     : parity mode encodings (none / even / odd)
//   ERR_*        : bit positions inside the 3-bit error vector
//   out_state_e  : output-register occupancy state
//   uart_frame_w : total captured frame width for a given configuration
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAMING = 1;
    localparam int ERR_OVERRUN = 2;
    localparam int ERR_W       = 3;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_FULL = 1'b1
    } out_state_e;

    // start bit + data bits + optional parity bit + stop bits
    function automatic int uart_frame_w(input int data_w, input int parity_mode,
                                        input int stop_bits);
        return 1 + data_w + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_sat_counter.sv
// -----------------------------------------------------------------------------
// uart_sat_counter
// Saturating event counter with synchronous clear.
//   clk   : system clock
//   rst   : asynchronous reset, active-high
//   inc   : count one event this cycle
//   clr   : synchronous clear, wins over a simultaneous inc
//   count : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module uart_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : uart_sat_counter

// File: rtl/uart_frame_checker.sv
// -----------------------------------------------------------------------------
// uart_frame_checker
// Takes a complete captured UART frame, checks start/parity/stop bits, pulls
// out the data word in wire order and hands it on over valid/ready together
// with error flags. Keeps saturating per-error statistics.
//
// Two registered stages: stage A holds the raw frame, stage B holds the checked
// result presented to the consumer. One frame per cycle when unthrottled.
//
// Build option:
//   UART_CHK_ZERO_ON_ERR_EN : when defined, results carrying a framing or
//                             parity error present out_data = 0 (flags and
//                             counters unaffected).
//
// Ports:
//   clk            : system clock
//   rst            : asynchronous reset, active-high
//   frame_valid    : one-cycle strobe, frame holds a complete frame
//   frame          : [FRAME_W-1] start, data (first wire bit highest),
//                    parity (if any), stop bit(s) at [STOP_BITS-1:0]
//   out_valid      : result available
//   out_ready      : consumer accepts result
//   out_data       : data word, out_data[i] = frame[FRAME_W-2-i]
//   out_err        : {overrun, framing, parity}, qualified by out_valid
//   clr_cnt        : synchronous clear of all counters
//   parity_err_cnt : results with a parity error
//   frame_err_cnt  : results with a framing error
//   overrun_cnt    : frames dropped because stage A could not accept them
// -----------------------------------------------------------------------------
module uart_frame_checker
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int CNT_W       = 8,
    localparam int FRAME_W    = uart_frame_w(DATA_W, PARITY_MODE, STOP_BITS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [ERR_W-1:0]   out_err,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   parity_err_cnt,
    output logic [CNT_W-1:0]   frame_err_cnt,
    output logic [CNT_W-1:0]   overrun_cnt
);

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    out_state_e         state_q, state_d;
    logic               a_valid_q, a_valid_d;
    logic [FRAME_W-1:0] a_frame_q, a_frame_d;
    logic               ovr_sticky_q, ovr_sticky_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [ERR_W-1:0]   out_err_q, out_err_d;

    logic b_load;     // stage A result moves into stage B this cycle
    logic a_load;     // incoming frame captured into stage A this cycle
    logic overrun;    // incoming frame has nowhere to go and is dropped

    // B can take A's contents when B is empty or is being emptied right now.
    assign b_load  = a_valid_q && ((state_q == OUT_IDLE) || out_ready);
    assign a_load  = frame_valid && (!a_valid_q || b_load);
    assign overrun = frame_valid && a_valid_q && !b_load;

    // ------------------------------------------------------------------
    // Frame checks on stage A contents
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] a_data;
    logic              start_err;
    logic              stop_err;
    logic              framing_err;
    logic              parity_err;

    // First wire bit sits just below the start bit and becomes the data LSB.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
            assign a_data[gi] = a_frame_q[FRAME_W-2-gi];
        end
    endgenerate

    assign start_err   = a_frame_q[FRAME_W-1];
    assign stop_err    = ~(&a_frame_q[STOP_BITS-1:0]);
    assign framing_err = start_err | stop_err;

    // Parity bit lives directly above the stop bits when present.
    generate
        if (PARITY_MODE == PARITY_EVEN) begin : g_par_even
            assign parity_err = a_frame_q[STOP_BITS] != (^a_data);
        end else if (PARITY_MODE == PARITY_ODD) begin : g_par_odd
            assign parity_err = a_frame_q[STOP_BITS] != ~(^a_data);
        end else begin : g_par_none
            assign parity_err = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        a_valid_d = a_valid_q;
        a_frame_d = a_frame_q;
        if (a_load) begin
            a_valid_d = 1'b1;
            a_frame_d = frame;
        end else if (b_load) begin
            a_valid_d = 1'b0;
        end
    end

    // The sticky overrun flag rides on the next result to enter stage B.
    // An overrun and a B load cannot coincide (overrun needs B blocked).
    always_comb begin
        ovr_sticky_d = ovr_sticky_q;
        if (b_load) begin
            ovr_sticky_d = 1'b0;
        end
        if (overrun) begin
            ovr_sticky_d = 1'b1;
        end
    end

    always_comb begin
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        if (b_load) begin
            out_err_d[ERR_PARITY]  = parity_err;
            out_err_d[ERR_FRAMING] = framing_err;
            out_err_d[ERR_OVERRUN] = ovr_sticky_q;
`ifdef UART_CHK_ZERO_ON_ERR_EN
            out_data_d = (framing_err || parity_err) ? '0 : a_data;
`else
            out_data_d = a_data;
`endif
        end
    end

    // Output occupancy FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_IDLE: begin
                if (b_load) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (out_ready) begin
                    state_d = b_load ? OUT_FULL : OUT_IDLE;
                end
            end
            default: state_d = OUT_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OUT_IDLE;
            a_valid_q    <= 1'b0;
            a_frame_q    <= '0;
            ovr_sticky_q <= 1'b0;
            out_data_q   <= '0;
            out_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            a_valid_q    <= a_valid_d;
            a_frame_q    <= a_frame_d;
            ovr_sticky_q <= ovr_sticky_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_valid = (state_q == OUT_FULL);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

    // ------------------------------------------------------------------
    // Statistics: error counters advance when the result enters stage B,
    // the overrun counter advances on the dropped frame itself.
    // ------------------------------------------------------------------
    uart_sat_counter #(.CNT_W(CNT_W)) u_parity_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (b_load && parity_err),
        .clr   (clr_cnt),
        .count (parity_err_cnt)
    );

    uart_sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (b_load && framing_err),
        .clr   (clr_cnt),
        .count (frame_err_cnt)
    );

    uart_sat_counter #(.CNT_W(CNT_W)) u_overrun_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (overrun),
        .clr   (clr_cnt),
        .count (overrun_cnt)
    );

endmodule : uart_frame_checker

// File: tb/tb_uart_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_checker
// Scoreboarded bench for uart_frame_checker. Expected results are pushed when a
// frame is driven into the default-configuration instance and popped when the
// instance hands a result over. A second instance (7 data bits, odd parity,
// two stop bits) is checked directly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_frame_checker;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // default instance: DATA_W=8, even parity, 1 stop bit
    logic        frame_valid;
    logic [10:0] frame;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_err;
    logic        clr_cnt;
    logic [7:0]  parity_err_cnt, frame_err_cnt, overrun_cnt;

    // 7-bit instance: odd parity, 2 stop bits
    logic        fv7;
    logic [10:0] frame7;
    logic        ov7;
    logic        rdy7;
    logic [6:0]  data7;
    logic [2:0]  err7;
    logic [7:0]  pcnt7, fcnt7, ocnt7;

    uart_frame_checker dut (
        .clk            (clk),
        .rst            (rst),
        .frame_valid    (frame_valid),
        .frame          (frame),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_err        (out_err),
        .clr_cnt        (clr_cnt),
        .parity_err_cnt (parity_err_cnt),
        .frame_err_cnt  (frame_err_cnt),
        .overrun_cnt    (overrun_cnt)
    );

    uart_frame_checker #(.DATA_W(7), .PARITY_MODE(2), .STOP_BITS(2), .CNT_W(8)) dut7 (
        .clk            (clk),
        .rst            (rst),
        .frame_valid    (fv7),
        .frame          (frame7),
        .out_valid      (ov7),
        .out_ready      (rdy7),
        .out_data       (data7),
        .out_err        (err7),
        .clr_cnt        (1'b0),
        .parity_err_cnt (pcnt7),
        .frame_err_cnt  (fcnt7),
        .overrun_cnt    (ocnt7)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] err;
    } exp_t;

    exp_t sb_q[$];

    // Reference: 8-bit even parity frame, wire LSB just below the start bit.
    function automatic exp_t model(input logic [10:0] f, input logic ovr);
        exp_t e;
        logic [7:0] d;
        logic fr, pa;
        for (int i = 0; i < 8; i++) d[i] = f[9-i];
        fr = f[10] | ~f[0];
        pa = f[1] ^ (^d);
        e.err = {ovr, fr, pa};
`ifdef UART_CHK_ZERO_ON_ERR_EN
        e.data = (fr | pa) ? 8'h00 : d;
`else
        e.data = d;
`endif
        return e;
    endfunction

    // Handshake monitor: a result transfers on the edge following a negedge
    // where out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {29'd0, out_err}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data", {24'd0, out_data}, {24'd0, e.data});
                chk("sb_err", {29'd0, out_err}, {29'd0, e.err});
                $display("txn data=%02h err=%03b exp_data=%02h exp_err=%03b",
                         out_data, out_err, e.data, e.err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [10:0] f, input bit expect_out, input logic ovr);
        frame_valid = 1'b1;
        frame       = f;
        if (expect_out) sb_q.push_back(model(f, ovr));
        tick();
        frame_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; frame_valid = 1'b0; frame = '0; out_ready = 1'b0; clr_cnt = 1'b0;
        fv7 = 1'b0; frame7 = '0; rdy7 = 1'b1;
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_data", {24'd0, out_data}, 0);
        chk("rst_err", {29'd0, out_err}, 0);
        chk("rst_pcnt", {24'd0, parity_err_cnt}, 0);
        chk("rst_fcnt", {24'd0, frame_err_cnt}, 0);
        chk("rst_ocnt", {24'd0, overrun_cnt}, 0);
        rst = 1'b0;
        tick();

        // latency: sampled at edge N, result registered at N+1
        out_ready = 1'b1;
        frame_valid = 1'b1; frame = 11'h295;
        sb_q.push_back(model(11'h295, 1'b0));
        tick();
        frame_valid = 1'b0;
        chk("lat_n", {31'd0, out_valid}, 0);
        tick();
        chk("lat_n1", {31'd0, out_valid}, 1);
        tick(); tick();

        // error patterns back to back
        send(11'h297, 1, 1'b0);
        send(11'h294, 1, 1'b0);
        send(11'h695, 1, 1'b0);
        tick(); tick(); tick();
        chk("pcnt_1", {24'd0, parity_err_cnt}, 1);
        chk("fcnt_2", {24'd0, frame_err_cnt}, 2);
        chk("ocnt_0", {24'd0, overrun_cnt}, 0);

        // backpressure and overrun
        out_ready = 1'b0;
        send(11'h295, 1, 1'b0);
        send(11'h295, 1, 1'b1);
        send(11'h295, 0, 1'b0);
        tick(); tick();
        chk("ovr_cnt", {24'd0, overrun_cnt}, 1);
        chk("ovr_hold_valid", {31'd0, out_valid}, 1);
        chk("ovr_hold_data", {24'd0, out_data}, 32'hA5);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("ovr_drained", {31'd0, out_valid}, 0);

        // saturation
        for (int i = 0; i < 300; i++) send(11'h297, 1, 1'b0);
        tick(); tick(); tick();
        chk("pcnt_sat", {24'd0, parity_err_cnt}, 255);

        // clear coincident with an error entering stage B
        frame_valid = 1'b1; frame = 11'h297;
        sb_q.push_back(model(11'h297, 1'b0));
        tick();
        frame_valid = 1'b0;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_pcnt", {24'd0, parity_err_cnt}, 0);
        chk("clr_fcnt", {24'd0, frame_err_cnt}, 0);
        chk("clr_ocnt", {24'd0, overrun_cnt}, 0);
        tick();
        chk("clr_stays", {24'd0, parity_err_cnt}, 0);
        tick(); tick();

        // reset with a frame in flight: nothing must come out
        frame_valid = 1'b1; frame = 11'h295;
        tick();
        frame_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("rst_mid_after", {31'd0, out_valid}, 0);

        // 7-bit, odd parity, 2 stop bits: data 7'h41
        fv7 = 1'b1; frame7 = 11'h20F;
        tick();
        fv7 = 1'b0;
        chk("d7_lat", {31'd0, ov7}, 0);
        tick();
        chk("d7_valid", {31'd0, ov7}, 1);
        chk("d7_data", {25'd0, data7}, 32'h41);
        chk("d7_err", {29'd0, err7}, 0);
        $display("txn7 data=%02h err=%03b", data7, err7);

        fv7 = 1'b1; frame7 = 11'h20B;   // parity bit cleared
        tick();
        fv7 = 1'b1; frame7 = 11'h20E;   // last stop bit cleared
        tick();
        fv7 = 1'b0;
        chk("d7_perr", {29'd0, err7}, 32'b001);
`ifdef UART_CHK_ZERO_ON_ERR_EN
        chk("d7_pdata", {25'd0, data7}, 0);
`else
        chk("d7_pdata", {25'd0, data7}, 32'h41);
`endif
        $display("txn7 data=%02h err=%03b", data7, err7);
        tick();
        chk("d7_ferr", {29'd0, err7}, 32'b010);
        $display("txn7 data=%02h err=%03b", data7, err7);
        tick();
        chk("d7_pcnt", {24'd0, pcnt7}, 1);
        chk("d7_fcnt", {24'd0, fcnt7}, 1);

        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_uart_frame_checker
